// File: rtl/hex_step_counter_if.sv
// ---------------------------------------------------------------------------
// hex_step_counter_if
//
// Pin bundle for hex_step_counter, following the TinyTapeout 8-in/8-out
// layout. Clock and reset (io_in[1:0] on the pad ring) are carried as plain
// scalar ports on the block, so this bundle only holds the remaining inputs.
//
//   io_in[2]    step button (asynchronous, bouncy)
//   io_in[3]    direction, 0 = up, 1 = down
//   io_in[4]    run enable, 1 = auto-run
//   io_in[7:5]  prescale select
//   io_out[3:0] count, bit-reversed (io_out[0] = MSB) for the hex decoder
//   io_out[4]   wrap pulse
//   io_out[5]   running flag
//   io_out[6]   step-accepted pulse
//   io_out[7]   heartbeat, toggles on every auto-run tick
//
// master: the side driving the pins (board / bench)
// slave : the counter itself
// ---------------------------------------------------------------------------
interface hex_step_counter_if;
   logic [7:2] io_in;
   logic [7:0] io_out;

   modport master (
      output io_in,
      input  io_out
   );

   modport slave (
      input  io_in,
      output io_out
   );
endinterface

// File: rtl/hex_step_counter.sv
// ---------------------------------------------------------------------------
// hex_step_counter
//
// Nibble source for the 7-segment hex decoder stage. A 4-bit count is moved
// by one either on a debounced rising edge of the step button or on a
// prescaled auto-run tick, in the direction chosen by the direction pin.
// The count is presented bit-reversed so io_out[3:0] wires straight into the
// decoder's io_in[3:0].
//
// Ports:
//   clk  - rising-edge clock for all state
//   rst  - asynchronous, active-high reset; clears all state
//   bus  - hex_step_counter_if.slave, pin-level inputs io_in[7:2] and the
//          registered outputs io_out[7:0]
//
// Parameters:
//   SYNC_STAGES     - synchronizer depth on each asynchronous input (>= 1)
//   DEBOUNCE_CYCLES - consecutive synchronized samples needed to accept a
//                     button level change (>= 1)
//   TICK_SHIFT_MIN  - log2 of the fastest auto-run tick period in clocks
// ---------------------------------------------------------------------------
module hex_step_counter #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int TICK_SHIFT_MIN  = 4
) (
   input  logic                clk,
   input  logic                rst,
   hex_step_counter_if.slave   bus
);

   // Prescaler is wide enough for the slowest select value (sel = 7 adds 14).
   localparam int PW = TICK_SHIFT_MIN + 14;

   // Debounce counter only has to reach DEBOUNCE_CYCLES-1; keep at least one
   // bit so the DEBOUNCE_CYCLES = 1 case still elaborates.
   localparam int DC_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DC_W-1:0] DC_LAST = DC_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {
      STOPPED = 1'b0,
      RUNNING = 1'b1
   } run_state_e;

   // ------------------------------------------------------------------------
   // Input synchronizers
   // ------------------------------------------------------------------------
   logic [7:2]  sync_q [SYNC_STAGES];
   logic        step_s;
   logic        dir_s;
   logic        run_s;
   logic [2:0]  sel_s;

   // ------------------------------------------------------------------------
   // Debounce, FSM, prescaler and count state
   // ------------------------------------------------------------------------
   logic            db_q;
   logic [DC_W-1:0] dc_q;
   logic            step_event;

   run_state_e      state_q;
   run_state_e      state_d;
   logic            enter_run;

   logic [PW-1:0]   prescaler_q;
   logic [PW-1:0]   tick_mask;
   logic            tick;

   logic [3:0]      count_q;
   logic            wrap_q;
   logic            step_ack_q;
   logic            heartbeat_q;
   logic            advance;
   logic            at_wrap_edge;

   // Every asynchronous pin runs through the same chain of SYNC_STAGES flops;
   // only the last stage is ever looked at by the rest of the design.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= bus.io_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign step_s = sync_q[SYNC_STAGES-1][2];
   assign dir_s  = sync_q[SYNC_STAGES-1][3];
   assign run_s  = sync_q[SYNC_STAGES-1][4];
   assign sel_s  = sync_q[SYNC_STAGES-1][7:5];

   // Debounce: the accepted level db only follows the synchronized button
   // once it has differed from db for DEBOUNCE_CYCLES consecutive samples.
   // Any agreeing sample throws the partial count away, so short glitches
   // never get through.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db_q <= 1'b0;
         dc_q <= '0;
      end else if (step_s == db_q) begin
         dc_q <= '0;
      end else if (dc_q == DC_LAST) begin
         db_q <= step_s;
         dc_q <= '0;
      end else begin
         dc_q <= dc_q + DC_W'(1);
      end
   end

   // The step event is the cycle in which db is about to rise. Decoding it
   // from the pre-edge state lets the count move on the same edge that db
   // rises, rather than one clock later.
   assign step_event = step_s & ~db_q & (dc_q == DC_LAST);

   // Run-state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= STOPPED;
      end else begin
         state_q <= state_d;
      end
   end

   // Run-state transitions. enter_run marks the STOPPED->RUNNING edge so the
   // prescaler can restart its phase from zero on entry.
   always_comb begin
      state_d   = state_q;
      enter_run = 1'b0;
      unique case (state_q)
         STOPPED: begin
            if (run_s) begin
               state_d   = RUNNING;
               enter_run = 1'b1;
            end
         end
         RUNNING: begin
            if (!run_s) begin
               state_d = STOPPED;
            end
         end
         default: begin
            state_d = STOPPED;
         end
      endcase
   end

   // Free-running prescaler while RUNNING, frozen while STOPPED. It is only
   // cleared on entry, so a select change mid-run simply starts comparing a
   // different number of low bits of the current value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prescaler_q <= '0;
      end else if (enter_run) begin
         prescaler_q <= '0;
      end else if (state_q == RUNNING) begin
         prescaler_q <= prescaler_q + PW'(1);
      end
   end

   // A tick fires when the low TICK_SHIFT_MIN+2*sel bits are all ones, i.e.
   // on the last count of each period, so the count moves exactly one period
   // after the entry edge.
   always_comb begin
      tick_mask = ~({PW{1'b1}} << (TICK_SHIFT_MIN + 2 * int'(sel_s)));
      tick      = (state_q == RUNNING) && ((prescaler_q & tick_mask) == tick_mask);
   end

   // A coincident step and tick still move the count by one; the wrap flag
   // is decided from the value being left so it lands on the wrapping edge.
   always_comb begin
      advance      = step_event | tick;
      at_wrap_edge = dir_s ? (count_q == 4'h0) : (count_q == 4'hF);
   end

   // Count and the registered status pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q     <= 4'h0;
         wrap_q      <= 1'b0;
         step_ack_q  <= 1'b0;
         heartbeat_q <= 1'b0;
      end else begin
         if (advance) begin
            count_q <= dir_s ? (count_q - 4'd1) : (count_q + 4'd1);
         end
         wrap_q     <= advance & at_wrap_edge;
         step_ack_q <= step_event;
         if (tick) begin
            heartbeat_q <= ~heartbeat_q;
         end
      end
   end

   // Output pins. The count is reversed so io_out[0] carries the MSB, the
   // bit order the decoder stage expects on its inputs.
   assign bus.io_out = {heartbeat_q,
                        step_ack_q,
                        (state_q == RUNNING),
                        wrap_q,
                        count_q[0], count_q[1], count_q[2], count_q[3]};

endmodule

// File: tb/tb_hex_step_counter.sv
// ---------------------------------------------------------------------------
// tb_hex_step_counter
//
// Directed bench for hex_step_counter with default parameters. Inputs change
// on the falling edge and outputs are sampled on the falling edge, so "edge
// n" below means the n-th rising edge after an input was changed.
// ---------------------------------------------------------------------------
module tb_hex_step_counter;

   logic clk;
   logic rst;

   hex_step_counter_if bus ();

   hex_step_counter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fails  = 0;

   logic       btn_v;
   logic       dir_v;
   logic       run_v;
   logic [2:0] sel_v;

   logic [3:0] exp_count;
   logic       hb_exp;

   int pulses;
   int moved;

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Display order of the count on io_out[3:0]: io_out[0] carries the MSB.
   function automatic logic [3:0] rev4(input logic [3:0] c);
      return {c[0], c[1], c[2], c[3]};
   endfunction

   task automatic applyStimulus();
      bus.io_in = {sel_v, run_v, dir_v, btn_v};
   endtask

   task automatic waitEdges(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // One clean press held 10 clocks followed by a 10-clock gap, counter
   // stopped. The step must land on edge 6 of the press.
   task automatic press(input logic [3:0] nxt, input logic wrap_exp);
      btn_v = 1'b1;
      applyStimulus();
      waitEdges(5);
      checkOutput("pre_step", bus.io_out, {hb_exp, 3'b000, rev4(exp_count)});
      waitEdges(1);
      checkOutput("step", bus.io_out, {hb_exp, 1'b1, 1'b0, wrap_exp, rev4(nxt)});
      waitEdges(1);
      checkOutput("step_end", bus.io_out, {hb_exp, 3'b000, rev4(nxt)});
      exp_count = nxt;
      waitEdges(3);
      btn_v = 1'b0;
      applyStimulus();
      waitEdges(10);
      checkOutput("release", bus.io_out, {hb_exp, 3'b000, rev4(exp_count)});
   endtask

   initial begin
      rst       = 1'b1;
      btn_v     = 1'b0;
      dir_v     = 1'b0;
      run_v     = 1'b0;
      sel_v     = 3'd0;
      exp_count = 4'h0;
      hb_exp    = 1'b0;
      applyStimulus();

      // Reset state and quiet idle after release.
      waitEdges(3);
      checkOutput("reset_hold", bus.io_out, 8'h00);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         waitEdges(1);
         checkOutput("idle_after_reset", bus.io_out, 8'h00);
      end

      // Manual steps up: 1, 2, 3.
      $display("[TB] manual steps");
      press(4'h1, 1'b0);
      press(4'h2, 1'b0);
      press(4'h3, 1'b0);

      // Bounce: toggle every 2 clocks for 20 clocks, no step may get through.
      $display("[TB] bounce rejection");
      pulses = 0;
      moved  = 0;
      for (int i = 0; i < 10; i++) begin
         btn_v = (i % 2 == 0);
         applyStimulus();
         for (int k = 0; k < 2; k++) begin
            waitEdges(1);
            if (bus.io_out[6]) pulses++;
            if (bus.io_out[3:0] != rev4(4'h3)) moved++;
         end
      end
      checkOutput("bounce_pulses", pulses, 0);
      checkOutput("bounce_count", moved, 0);
      press(4'h4, 1'b0);

      // Walk up to F, then wrap up and back down.
      $display("[TB] wrap");
      for (int i = 5; i < 16; i++) begin
         press(4'(i), 1'b0);
      end
      press(4'h0, 1'b1);
      dir_v = 1'b1;
      applyStimulus();
      waitEdges(5);
      press(4'hF, 1'b1);
      press(4'hE, 1'b0);

      // Auto-run, sel = 0: entry on edge 3, ticks on 19, 35, 51, ...
      $display("[TB] auto-run");
      dir_v = 1'b0;
      run_v = 1'b1;
      sel_v = 3'd0;
      applyStimulus();
      waitEdges(2);
      checkOutput("run_not_yet", bus.io_out, 8'h07);
      waitEdges(1);
      checkOutput("run_entry", bus.io_out, 8'h27);
      waitEdges(15);
      checkOutput("before_tick1", bus.io_out, 8'h27);
      waitEdges(1);
      checkOutput("tick1", bus.io_out, 8'hAF);
      waitEdges(15);
      checkOutput("before_tick2", bus.io_out, 8'hAF);
      waitEdges(1);
      checkOutput("tick2_wrap", bus.io_out, 8'h30);
      waitEdges(1);
      checkOutput("tick2_wrap_end", bus.io_out, 8'h20);
      waitEdges(15);
      checkOutput("tick3", bus.io_out, 8'hA8);

      // sel = 1 from edge 52 on: next tick on 67, then 131.
      sel_v = 3'd1;
      applyStimulus();
      waitEdges(15);
      checkOutput("before_tick4", bus.io_out, 8'hA8);
      waitEdges(1);
      checkOutput("tick4", bus.io_out, 8'h24);
      waitEdges(16);
      checkOutput("no_tick_sel1", bus.io_out, 8'h24);
      waitEdges(47);
      checkOutput("before_tick5", bus.io_out, 8'h24);
      waitEdges(1);
      checkOutput("tick5", bus.io_out, 8'hAC);

      // Stop: running flag drops on edge 3, count holds.
      run_v = 1'b0;
      applyStimulus();
      waitEdges(2);
      checkOutput("stop_not_yet", bus.io_out, 8'hAC);
      waitEdges(1);
      checkOutput("stopped", bus.io_out, 8'h8C);
      waitEdges(200);
      checkOutput("stopped_hold", bus.io_out, 8'h8C);

      // Coincidence: step event and first tick both on edge 19.
      $display("[TB] step/tick coincidence");
      run_v = 1'b1;
      sel_v = 3'd0;
      applyStimulus();
      waitEdges(13);
      btn_v = 1'b1;
      applyStimulus();
      waitEdges(5);
      checkOutput("coinc_before", bus.io_out, 8'hAC);
      waitEdges(1);
      checkOutput("coinc", bus.io_out, 8'h62);
      waitEdges(1);
      checkOutput("coinc_after", bus.io_out, 8'h22);
      btn_v = 1'b0;
      run_v = 1'b0;
      applyStimulus();
      waitEdges(15);
      checkOutput("coinc_stopped", bus.io_out, 8'h02);
      exp_count = 4'h4;
      hb_exp    = 1'b0;

      // Reset mid-count with the button held through release.
      $display("[TB] async reset");
      press(4'h5, 1'b0);
      press(4'h6, 1'b0);
      press(4'h7, 1'b0);
      checkOutput("pre_reset", bus.io_out, 8'h0E);
      btn_v = 1'b1;
      applyStimulus();
      waitEdges(2);
      #2 rst = 1'b1;
      #1 checkOutput("async_reset", bus.io_out, 8'h00);
      @(negedge clk);
      waitEdges(2);
      rst = 1'b0;
      exp_count = 4'h0;
      waitEdges(5);
      checkOutput("held_pre_step", bus.io_out, 8'h00);
      waitEdges(1);
      checkOutput("held_step", bus.io_out, 8'h48);
      waitEdges(1);
      checkOutput("held_step_end", bus.io_out, 8'h08);
      btn_v = 1'b0;
      applyStimulus();
      waitEdges(10);
      checkOutput("held_release", bus.io_out, 8'h08);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
